// File: rtl/branch_seq_ctrl.sv
// Branch resolution sequencer: accepts one branch op, waits for rd1, evaluates
// JMP/BEQZ/BNEZ, then issues a one-cycle PC redirect and a timed flush.
// Optional br_total/br_taken counters are enabled by defining BRANCH_SEQ_STATS_EN.
module branch_seq_ctrl #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [1:0]      br_type,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_offset,
  input  logic [XLEN-1:0] rd1,
  input  logic            rd1_valid,
  input  logic            kill,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            bad_type
`ifdef BRANCH_SEQ_STATS_EN
  ,
  output logic [15:0]     br_total,
  output logic [15:0]     br_taken
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_WAIT_OP = 2'b01,
    S_EVAL    = 2'b10,
    S_FLUSH   = 2'b11
  } state_t;

  localparam logic [1:0] T_JMP  = 2'b00;
  localparam logic [1:0] T_BEQZ = 2'b01;
  localparam logic [1:0] T_BNEZ = 2'b10;
  localparam logic [1:0] T_RSVD = 2'b11;
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

  // Target is word-aligned: the offset counts words, its top two bits fall off.
  function automatic logic [XLEN-1:0] branch_target(
    input logic [XLEN-1:0]        pc,
    input logic signed [XLEN-1:0] off
  );
    return pc + XLEN'(off <<< 2);
  endfunction

  state_t                 state_q, state_d;
  logic [1:0]             type_q, type_d;
  logic [XLEN-1:0]        pc_q, pc_d;
  logic signed [XLEN-1:0] off_q, off_d;
  logic [XLEN-1:0]        rd1_q, rd1_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   br_ready_q, br_ready_d;
  logic                   redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]        redirect_pc_q, redirect_pc_d;
  logic                   flush_q, flush_d;
  logic                   stall_q, stall_d;
  logic                   busy_q, busy_d;
  logic                   bad_type_q, bad_type_d;
  logic                   eval_fire;
  logic                   taken;

  always_comb begin
    state_d          = state_q;
    type_d           = type_q;
    pc_d             = pc_q;
    off_d            = off_q;
    rd1_d            = rd1_q;
    cnt_d            = cnt_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    bad_type_d       = bad_type_q;
    eval_fire        = 1'b0;
    taken            = 1'b0;

    if (kill) begin
      // Abort drops the op outright; bad_type and redirect_pc keep their values.
      state_d = S_IDLE;
      cnt_d   = 4'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (br_valid && br_ready_q) begin
            type_d = br_type;
            pc_d   = br_pc;
            off_d  = br_offset;
            if (rd1_valid) begin
              rd1_d   = rd1;
              state_d = S_EVAL;
            end else begin
              state_d = S_WAIT_OP;
            end
          end
        end
        S_WAIT_OP: begin
          if (rd1_valid) begin
            rd1_d   = rd1;
            state_d = S_EVAL;
          end
        end
        S_EVAL: begin
          eval_fire = 1'b1;
          unique case (type_q)
            T_JMP:   taken = 1'b1;
            T_BEQZ:  taken = (rd1_q == '0);
            T_BNEZ:  taken = (rd1_q != '0);
            T_RSVD:  taken = 1'b0;
            default: taken = 1'b0;
          endcase
          if (type_q == T_RSVD) begin
            bad_type_d = 1'b1;
          end
          if (taken) begin
            redirect_valid_d = 1'b1;
            redirect_pc_d    = branch_target(pc_q, off_q);
            cnt_d            = FLUSH_INIT;
            state_d          = S_FLUSH;
          end else begin
            redirect_pc_d = pc_q + XLEN'(4);
            state_d       = S_IDLE;
          end
        end
        S_FLUSH: begin
          if (cnt_q <= 4'd1) begin
            cnt_d   = 4'd0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Status outputs are registered copies of the next state's decode.
    br_ready_d = (state_d == S_IDLE);
    stall_d    = (state_d == S_WAIT_OP);
    flush_d    = (state_d == S_FLUSH);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      type_q           <= 2'b00;
      pc_q             <= '0;
      off_q            <= '0;
      rd1_q            <= '0;
      cnt_q            <= 4'd0;
      br_ready_q       <= 1'b1;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      flush_q          <= 1'b0;
      stall_q          <= 1'b0;
      busy_q           <= 1'b0;
      bad_type_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      type_q           <= type_d;
      pc_q             <= pc_d;
      off_q            <= off_d;
      rd1_q            <= rd1_d;
      cnt_q            <= cnt_d;
      br_ready_q       <= br_ready_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      stall_q          <= stall_d;
      busy_q           <= busy_d;
      bad_type_q       <= bad_type_d;
    end
  end

  assign br_ready       = br_ready_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign stall          = stall_q;
  assign busy           = busy_q;
  assign bad_type       = bad_type_q;

`ifdef BRANCH_SEQ_STATS_EN
  logic [15:0] br_total_q, br_total_d;
  logic [15:0] br_taken_q, br_taken_d;

  always_comb begin
    br_total_d = br_total_q;
    br_taken_d = br_taken_q;
    if (eval_fire && (br_total_q != 16'hFFFF)) begin
      br_total_d = br_total_q + 16'd1;
    end
    if (eval_fire && taken && (br_taken_q != 16'hFFFF)) begin
      br_taken_d = br_taken_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_total_q <= 16'd0;
      br_taken_q <= 16'd0;
    end else begin
      br_total_q <= br_total_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign br_total = br_total_q;
  assign br_taken = br_taken_q;
`endif

endmodule
